// File: rtl/noc_pkg.sv
// noc_pkg: router-wide constants, allocator state type and round-robin index helper.
package noc_pkg;
   localparam int PORT_NUM = 5;
   localparam int PORT_W   = 3;
   localparam int STAT_W   = 16;
   localparam int PORT_N   = 0;
   localparam int PORT_E   = 1;
   localparam int PORT_S   = 2;
   localparam int PORT_W_  = 3;
   localparam int PORT_L   = 4;
   typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_e;
   function automatic logic [PORT_W-1:0] wrap_add(logic [PORT_W-1:0] a, int k);
      return PORT_W'((int'(a) + k) % PORT_NUM);
   endfunction
endpackage

// File: rtl/sw_alloc_if.sv
// sw_alloc_if: request/grant/crossbar bundle between route computation, allocator and crossbar.
// stall_cnt exists only when SW_ALLOC_STATS_EN is defined.
interface sw_alloc_if;
   import noc_pkg::*;
   logic [PORT_NUM-1:0]             req;
   logic [PORT_NUM-1:0][PORT_W-1:0] port;
   logic [PORT_NUM-1:0]             head;
   logic [PORT_NUM-1:0]             tail;
   logic [PORT_NUM-1:0]             ready;
   logic [PORT_NUM-1:0]             grant;
   logic [PORT_NUM-1:0]             valid;
   logic [PORT_NUM-1:0][PORT_W-1:0] sel;
`ifdef SW_ALLOC_STATS_EN
   logic [PORT_NUM-1:0][STAT_W-1:0] stall_cnt;
   modport master (output req, port, head, tail, ready, input grant, valid, sel, stall_cnt);
   modport slave  (input req, port, head, tail, ready, output grant, valid, sel, stall_cnt);
`else
   modport master (output req, port, head, tail, ready, input grant, valid, sel);
   modport slave  (input req, port, head, tail, ready, output grant, valid, sel);
`endif
endinterface

// File: rtl/sw_alloc_rr_arbiter.sv
// rr_arbiter: PORT_NUM-way round-robin, priority starts at ptr+1 and wraps.
module rr_arbiter
   import noc_pkg::*;
(
   input  logic [PORT_NUM-1:0] req,
   input  logic [PORT_W-1:0]   ptr,
   output logic [PORT_NUM-1:0] gnt,
   output logic [PORT_W-1:0]   idx
);
   // Scan farthest to nearest so the nearest requester overwrites any earlier hit.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = PORT_NUM; k >= 1; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            gnt = PORT_NUM'(1) << wrap_add(ptr, k);
            idx = wrap_add(ptr, k);
         end
      end
   end
endmodule

// File: rtl/sw_alloc.sv
// sw_alloc: 5-port wormhole switch allocator, per-output round-robin with head-to-tail locking.
// Define SW_ALLOC_STATS_EN to add saturating per-output stall counters.
module sw_alloc
   import noc_pkg::*;
(
   input logic       clk,
   input logic       rst_n,
   sw_alloc_if.slave bus
);
   alloc_state_e        state_q [PORT_NUM];
   alloc_state_e        state_d [PORT_NUM];
   logic [PORT_W-1:0]   owner_q [PORT_NUM];
   logic [PORT_W-1:0]   owner_d [PORT_NUM];
   logic [PORT_W-1:0]   ptr_q   [PORT_NUM];
   logic [PORT_W-1:0]   ptr_d   [PORT_NUM];
   logic [PORT_NUM-1:0] cand    [PORT_NUM];
   logic [PORT_NUM-1:0] agnt    [PORT_NUM];
   logic [PORT_W-1:0]   aidx    [PORT_NUM];
   logic [PORT_W-1:0]   wsel    [PORT_NUM];
   logic [PORT_NUM-1:0] hit, locked, gnt, grant_v;
   logic [PORT_NUM-1:0][PORT_W-1:0] sel_v;
   // Out-of-range port values never match o, so they drop out here.
   always_comb begin
      for (int o = 0; o < PORT_NUM; o++)
         for (int i = 0; i < PORT_NUM; i++)
            cand[o][i] = bus.req[i] & bus.head[i] & (bus.port[i] == PORT_W'(o));
   end
   for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
      rr_arbiter u_arb (.req(cand[o]), .ptr(ptr_q[o]), .gnt(agnt[o]), .idx(aidx[o]));
   end
   always_comb begin
      grant_v = '0;
      sel_v   = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         locked[o]  = state_q[o] == ALLOC_LOCKED;
         hit[o]     = bus.req[owner_q[o]] & (bus.port[owner_q[o]] == PORT_W'(o));
         gnt[o]     = rst_n & bus.ready[o] & (locked[o] ? hit[o] : |agnt[o]);
         wsel[o]    = locked[o] ? owner_q[o] : aidx[o];
         sel_v[o]   = (locked[o] | gnt[o]) ? wsel[o] : '0;
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         if (gnt[o]) begin
            state_d[o] = bus.tail[wsel[o]] ? ALLOC_IDLE : ALLOC_LOCKED;
            owner_d[o] = bus.tail[wsel[o]] ? owner_q[o] : wsel[o];
            ptr_d[o]   = bus.tail[wsel[o]] ? wsel[o] : ptr_q[o];
         end
         for (int i = 0; i < PORT_NUM; i++)
            grant_v[i] = grant_v[i] | (gnt[o] & (wsel[o] == PORT_W'(i)));
      end
   end
   assign bus.grant = grant_v;
   assign bus.valid = gnt;
   assign bus.sel   = sel_v;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < PORT_NUM; o++) begin
            state_q[o] <= ALLOC_IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= PORT_W'(PORT_NUM - 1);
         end
      end else begin
         for (int o = 0; o < PORT_NUM; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
      end
   end
`ifdef SW_ALLOC_STATS_EN
   logic [STAT_W-1:0] stall_q [PORT_NUM];
   logic [STAT_W-1:0] stall_d [PORT_NUM];
   // A stall is any cycle with an eligible requester (idle head or locked owner) but no grant.
   always_comb begin
      for (int o = 0; o < PORT_NUM; o++)
         stall_d[o] = ((|cand[o] | (locked[o] & hit[o])) & ~gnt[o] & ~&stall_q[o]) ? stall_q[o] + 1'b1 : stall_q[o];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < PORT_NUM; o++) stall_q[o] <= '0;
      end else begin
         for (int o = 0; o < PORT_NUM; o++) stall_q[o] <= stall_d[o];
      end
   end
   for (genvar o = 0; o < PORT_NUM; o++) begin : g_stat
      assign bus.stall_cnt[o] = stall_q[o];
   end
`endif
endmodule

// File: tb/tb_sw_alloc.sv
// tb_sw_alloc: directed checks of arbitration, locking, back-pressure and reset for sw_alloc.
module tb_sw_alloc;
   import noc_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total = 0;
   int   rot [3] = '{0, 2, 4};
   always #5 clk = ~clk;
   sw_alloc_if bus ();
   sw_alloc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask
   task automatic put(int i, int p, bit h, bit t);
      bus.req[i]  = 1'b1;
      bus.port[i] = PORT_W'(p);
      bus.head[i] = h;
      bus.tail[i] = t;
   endtask
   task automatic drop(int i);
      bus.req[i]  = 1'b0;
      bus.port[i] = '0;
      bus.head[i] = 1'b0;
      bus.tail[i] = 1'b0;
   endtask
   function automatic logic [14:0] sv(int o, int i);
      return 15'(i) << (PORT_W * o);
   endfunction
   // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
   task automatic look(string tag, logic [4:0] g, logic [4:0] v, logic [14:0] s);
      #1;
      chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
      chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
      chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
      @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n     = 1'b0;
      bus.ready = 5'b11111;
      for (int i = 0; i < PORT_NUM; i++) drop(i);
      put(0, 1, 1, 1);
      @(negedge clk);
      @(negedge clk);
      look("rst", 5'b00000, 5'b00000, 15'h0);
      drop(0);
      rst_n = 1'b1;
      @(negedge clk);
      put(0, 1, 1, 1);
      look("t1", 5'b00001, 5'b00010, sv(1, 0));
      put(1, 1, 1, 1);
      look("t1_rr", 5'b00010, 5'b00010, sv(1, 1));
      drop(1);
      look("t1_wrap", 5'b00001, 5'b00010, sv(1, 0));
      drop(0);
      put(0, 4, 1, 1);
      put(2, 4, 1, 1);
      put(4, 4, 1, 1);
      for (int k = 0; k < 6; k++)
         look($sformatf("t2_%0d", k), 5'(1 << rot[k % 3]), 5'b10000, sv(4, rot[k % 3]));
      for (int i = 0; i < PORT_NUM; i++) drop(i);
      put(2, 2, 1, 1);
      look("t3_pre", 5'b00100, 5'b00100, sv(2, 2));
      drop(2);
      put(3, 2, 1, 0);
      put(1, 2, 1, 1);
      look("t3_head", 5'b01000, 5'b00100, sv(2, 3));
      put(3, 2, 0, 0);
      look("t3_body1", 5'b01000, 5'b00100, sv(2, 3));
      look("t3_body2", 5'b01000, 5'b00100, sv(2, 3));
      put(3, 2, 0, 1);
      look("t3_tail", 5'b01000, 5'b00100, sv(2, 3));
      drop(3);
      look("t3_in1", 5'b00010, 5'b00100, sv(2, 1));
      drop(1);
      put(4, 2, 1, 0);
      look("t4_head", 5'b10000, 5'b00100, sv(2, 4));
      put(4, 2, 0, 0);
      put(1, 2, 1, 1);
      bus.ready = 5'b11011;
      look("t4_stall1", 5'b00000, 5'b00000, sv(2, 4));
      look("t4_stall2", 5'b00000, 5'b00000, sv(2, 4));
`ifdef SW_ALLOC_STATS_EN
      chk("t4_cnt2", 32'(bus.stall_cnt[2]), 32'd2);
      chk("t4_cnt1", 32'(bus.stall_cnt[1]), 32'd0);
`endif
      bus.ready = 5'b11111;
      look("t4_body", 5'b10000, 5'b00100, sv(2, 4));
      put(4, 2, 0, 1);
      look("t4_tail", 5'b10000, 5'b00100, sv(2, 4));
      drop(4);
      look("t4_in1", 5'b00010, 5'b00100, sv(2, 1));
      drop(1);
`ifdef SW_ALLOC_STATS_EN
      chk("t4_cnt_hold", 32'(bus.stall_cnt[2]), 32'd2);
`endif
      put(0, 1, 1, 1);
      put(1, 2, 1, 1);
      put(2, 3, 1, 1);
      put(3, 0, 1, 1);
      put(4, 4, 1, 1);
      look("t5_all", 5'b11111, 5'b11111, 15'h4443);
      for (int i = 0; i < PORT_NUM; i++) drop(i);
      put(1, 5, 1, 1);
      look("bad_port", 5'b00000, 5'b00000, 15'h0);
      drop(1);
      put(2, 3, 1, 0);
      look("t6_head", 5'b00100, 5'b01000, sv(3, 2));
      put(2, 3, 0, 0);
      rst_n = 1'b0;
      look("t6_rst", 5'b00000, 5'b00000, 15'h0);
`ifdef SW_ALLOC_STATS_EN
      chk("t6_cnt_clr", 32'(bus.stall_cnt[2]), 32'd0);
`endif
      rst_n = 1'b1;
      put(0, 3, 1, 0);
      put(4, 3, 1, 0);
      look("t6_new", 5'b00001, 5'b01000, sv(3, 0));
      put(0, 3, 0, 1);
      look("t6_tail", 5'b00001, 5'b01000, sv(3, 0));
      for (int i = 0; i < PORT_NUM; i++) drop(i);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
